// File: rtl/alu_if.sv
// Operand/opcode and result bundle for the registered 16-bit ALU.
// There is no handshake: the master drives operation/in1/in2 every cycle, the slave registers a result every cycle.
interface alu_if;
  logic [3:0]  operation;
  logic [15:0] in1;
  logic [15:0] in2;
  logic [15:0] rd;
  logic        carry;
  logic        eq;
  logic        neg;

  modport master (
    output operation, in1, in2,
    input  rd, carry, eq, neg
  );

  modport slave (
    input  operation, in1, in2,
    output rd, carry, eq, neg
  );
endinterface

// File: rtl/alu.sv
// 16-bit registered integer ALU: result and carry/eq/neg flags update one clk edge after inputs are sampled.
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0100;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_SRA = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ROR = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1100;

  logic [3:0]  sh;
  logic [16:0] sum17;
  logic [16:0] diff17;
  logic [31:0] shl_w;
  logic [31:0] shr_w;
  logic [31:0] sra_w;
  logic [31:0] rol_w;
  logic [31:0] ror_w;
  logic [31:0] prod;
  logic [15:0] rd_next;
  logic        carry_next;

  assign sh     = bus.in2[3:0];
  assign sum17  = {1'b0, bus.in1} + {1'b0, bus.in2};
  assign diff17 = {1'b0, bus.in1} - {1'b0, bus.in2};
  assign prod   = bus.in1 * bus.in2;

  // Widened shifts keep the shifted-out bit in a fixed position (bit 16 or bit 15),
  // which also yields carry=0 for a shift amount of zero.
  assign shl_w = {16'h0000, bus.in1} << sh;
  assign shr_w = {bus.in1, 16'h0000} >> sh;
  assign sra_w = $signed({bus.in1, 16'h0000}) >>> sh;
  assign rol_w = {bus.in1, bus.in1} << sh;
  assign ror_w = {bus.in1, bus.in1} >> sh;

  always_comb begin
    rd_next    = 16'h0000;
    carry_next = 1'b0;
    case (bus.operation)
      OP_ADD: {carry_next, rd_next} = sum17;
      OP_SUB: {carry_next, rd_next} = diff17;
      OP_AND: rd_next = bus.in1 & bus.in2;
      OP_OR:  rd_next = bus.in1 | bus.in2;
      OP_XOR: rd_next = bus.in1 ^ bus.in2;
      OP_NOT: rd_next = ~bus.in1;
      OP_SHL: begin
        rd_next    = shl_w[15:0];
        carry_next = shl_w[16];
      end
      OP_SHR: begin
        rd_next    = shr_w[31:16];
        carry_next = shr_w[15];
      end
      OP_SRA: begin
        rd_next    = sra_w[31:16];
        carry_next = sra_w[15];
      end
      OP_ROL: begin
        rd_next    = rol_w[31:16];
        carry_next = (sh != 4'd0) & rol_w[16];
      end
      OP_ROR: begin
        rd_next    = ror_w[15:0];
        carry_next = (sh != 4'd0) & ror_w[15];
      end
      OP_MUL: begin
        rd_next    = prod[15:0];
        carry_next = |prod[31:16];
      end
      default: begin
        rd_next    = 16'h0000;
        carry_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd    <= 16'h0000;
      bus.carry <= 1'b0;
      bus.eq    <= 1'b0;
      bus.neg   <= 1'b0;
    end else begin
      bus.rd    <= rd_next;
      bus.carry <= carry_next;
      bus.eq    <= (bus.in1 == bus.in2);
      bus.neg   <= rd_next[15];
    end
  end
endmodule

// File: tb/tb_alu.sv
// Directed bench for the registered ALU: per-feature tasks with hand-computed vectors.
module tb_alu;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] rd;
    logic        c;
    logic        e;
    logic        n;
  } vec_t;

  logic [18:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: present an operation, let one edge pass, settle 1 time unit
  task automatic drive_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.operation = op;
    bus.in1       = a;
    bus.in2       = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_op(4'b0001, 16'h0005, 16'h0005);
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset[%0d]: got rd=%h c=%b eq=%b neg=%b, want rd=0000 c=0 eq=0 neg=0",
                 i, bus.rd, bus.carry, bus.eq, bus.neg);
      end
    end
    rst = 1'b0;
    drive_op(4'b0001, 16'd24, 16'd26);
    checks++;
    if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {16'd50, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL first_add: got rd=%h c=%b eq=%b neg=%b, want rd=0032 c=0 eq=0 neg=0",
               bus.rd, bus.carry, bus.eq, bus.neg);
    end
  endtask

  task automatic test_arith();
    vec_t v [0:4];
    v = '{
      '{4'b0010, 16'd24,    16'd3,     16'd21,    1'b0, 1'b0, 1'b0},
      '{4'b0010, 16'd3,     16'd24,    16'hFFEB,  1'b1, 1'b0, 1'b1},
      '{4'b0010, 16'd5,     16'd5,     16'h0000,  1'b0, 1'b1, 1'b0},
      '{4'b0001, 16'hFFFF,  16'h0001,  16'h0000,  1'b1, 1'b0, 1'b0},
      '{4'b0001, 16'h8000,  16'h8000,  16'h0000,  1'b1, 1'b1, 1'b0}
    };
    for (int i = 0; i < 5; i++) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {v[i].rd, v[i].c, v[i].e, v[i].n}) begin
        failures++;
        $display("FAIL arith[%0d] op=%b a=%h b=%h: got rd=%h c=%b eq=%b neg=%b, want rd=%h c=%b eq=%b neg=%b",
                 i, v[i].op, v[i].a, v[i].b, bus.rd, bus.carry, bus.eq, bus.neg,
                 v[i].rd, v[i].c, v[i].e, v[i].n);
      end
    end
  endtask

  task automatic test_logic();
    vec_t v [0:4];
    v = '{
      '{4'b0011, 16'd24,    16'd3,     16'h0000,  1'b0, 1'b0, 1'b0},
      '{4'b0100, 16'd24,    16'd3,     16'd27,    1'b0, 1'b0, 1'b0},
      '{4'b0101, 16'd24,    16'd3,     16'd27,    1'b0, 1'b0, 1'b0},
      '{4'b0110, 16'd24,    16'd0,     16'hFFE7,  1'b0, 1'b0, 1'b1},
      '{4'b0011, 16'hFFFF,  16'hFFFF,  16'hFFFF,  1'b0, 1'b1, 1'b1}
    };
    for (int i = 0; i < 5; i++) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {v[i].rd, v[i].c, v[i].e, v[i].n}) begin
        failures++;
        $display("FAIL logic[%0d] op=%b a=%h b=%h: got rd=%h c=%b eq=%b neg=%b, want rd=%h c=%b eq=%b neg=%b",
                 i, v[i].op, v[i].a, v[i].b, bus.rd, bus.carry, bus.eq, bus.neg,
                 v[i].rd, v[i].c, v[i].e, v[i].n);
      end
    end
  endtask

  task automatic test_shift();
    vec_t v [0:11];
    v = '{
      '{4'b0111, 16'd24,    16'd3,     16'd192,   1'b0, 1'b0, 1'b0},
      '{4'b1000, 16'd24,    16'd3,     16'd3,     1'b0, 1'b0, 1'b0},
      '{4'b1001, 16'h8000,  16'd3,     16'hF000,  1'b0, 1'b0, 1'b1},
      '{4'b1010, 16'h8001,  16'd1,     16'h0003,  1'b1, 1'b0, 1'b0},
      '{4'b0111, 16'h8001,  16'd1,     16'h0002,  1'b1, 1'b0, 1'b0},
      '{4'b1000, 16'h0001,  16'd1,     16'h0000,  1'b1, 1'b1, 1'b0},
      '{4'b1011, 16'h0001,  16'd1,     16'h8000,  1'b1, 1'b1, 1'b1},
      '{4'b0111, 16'h1234,  16'h0010,  16'h1234,  1'b0, 1'b0, 1'b0},
      '{4'b1010, 16'h8001,  16'h0020,  16'h8001,  1'b0, 1'b0, 1'b1},
      '{4'b0111, 16'h0003,  16'd15,    16'h8000,  1'b1, 1'b0, 1'b1},
      '{4'b1001, 16'h8001,  16'd1,     16'hC000,  1'b1, 1'b0, 1'b1},
      '{4'b1011, 16'h1234,  16'd4,     16'h4123,  1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {v[i].rd, v[i].c, v[i].e, v[i].n}) begin
        failures++;
        $display("FAIL shift[%0d] op=%b a=%h b=%h: got rd=%h c=%b eq=%b neg=%b, want rd=%h c=%b eq=%b neg=%b",
                 i, v[i].op, v[i].a, v[i].b, bus.rd, bus.carry, bus.eq, bus.neg,
                 v[i].rd, v[i].c, v[i].e, v[i].n);
      end
    end
  endtask

  task automatic test_mul_reserved();
    vec_t v [0:5];
    v = '{
      '{4'b1100, 16'd24,    16'd3,     16'd72,    1'b0, 1'b0, 1'b0},
      '{4'b1100, 16'h0100,  16'h0100,  16'h0000,  1'b1, 1'b1, 1'b0},
      '{4'b1100, 16'hFFFF,  16'hFFFF,  16'h0001,  1'b1, 1'b1, 1'b0},
      '{4'b1111, 16'd24,    16'd3,     16'h0000,  1'b0, 1'b0, 1'b0},
      '{4'b0000, 16'd7,     16'd7,     16'h0000,  1'b0, 1'b1, 1'b0},
      '{4'b1101, 16'hFFFF,  16'h0000,  16'h0000,  1'b0, 1'b0, 1'b0}
    };
    for (int i = 0; i < 6; i++) begin
      drive_op(v[i].op, v[i].a, v[i].b);
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {v[i].rd, v[i].c, v[i].e, v[i].n}) begin
        failures++;
        $display("FAIL mul_res[%0d] op=%b a=%h b=%h: got rd=%h c=%b eq=%b neg=%b, want rd=%h c=%b eq=%b neg=%b",
                 i, v[i].op, v[i].a, v[i].b, bus.rd, bus.carry, bus.eq, bus.neg,
                 v[i].rd, v[i].c, v[i].e, v[i].n);
      end
    end
  endtask

  // consecutive edges, one op each, with a reset cycle in the middle
  task automatic test_back_to_back();
    vec_t        v [0:6];
    logic [6:0]  rst_pat;
    logic [18:0] exp;
    v = '{
      '{4'b0001, 16'd1,     16'd2,     16'd3,     1'b0, 1'b0, 1'b0},
      '{4'b0101, 16'hAAAA,  16'h5555,  16'hFFFF,  1'b0, 1'b0, 1'b1},
      '{4'b1100, 16'd100,   16'd100,   16'h0000,  1'b0, 1'b0, 1'b0},
      '{4'b0010, 16'd10,    16'd1,     16'd9,     1'b0, 1'b0, 1'b0},
      '{4'b0110, 16'h00FF,  16'h00FF,  16'hFF00,  1'b0, 1'b1, 1'b1},
      '{4'b1011, 16'h0003,  16'd1,     16'h8001,  1'b1, 1'b0, 1'b1},
      '{4'b1000, 16'h8000,  16'd15,    16'h0001,  1'b0, 1'b0, 1'b0}
    };
    rst_pat = 7'b0000100;
    for (int i = 0; i < 7; i++)
      exp_q.push_back({v[i].rd, v[i].c, v[i].e, v[i].n});
    for (int i = 0; i < 7; i++) begin
      rst = rst_pat[i];
      drive_op(v[i].op, v[i].a, v[i].b);
      exp = exp_q.pop_front();
      checks++;
      if ({bus.rd, bus.carry, bus.eq, bus.neg} !== exp) begin
        failures++;
        $display("FAIL b2b[%0d] rst=%b: got rd=%h c=%b eq=%b neg=%b, want rd=%h c=%b eq=%b neg=%b",
                 i, rst, bus.rd, bus.carry, bus.eq, bus.neg, exp[18:3], exp[2], exp[1], exp[0]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    drive_op(4'b0001, 16'h1000, 16'h2000);
    bus.operation = 4'b0110;
    bus.in1       = 16'h0000;
    bus.in2       = 16'h0000;
    #3;
    checks++;
    if ({bus.rd, bus.carry, bus.eq, bus.neg} !== {16'h3000, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL hold: got rd=%h c=%b eq=%b neg=%b, want rd=3000 c=0 eq=0 neg=0",
               bus.rd, bus.carry, bus.eq, bus.neg);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.operation = 4'b0000;
    bus.in1       = 16'h0000;
    bus.in2       = 16'h0000;
    @(negedge clk);
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul_reserved();
    test_back_to_back();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
